// File: rtl/command_issuer.sv
// Initiator for the 12-bit command/syscall controller interface: queues host
// commands, issues them one at a time and captures the ALU result and flags.
module command_issuer #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [11:0]              host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    output logic [11:0]              command,
    output logic                     syscall,
    input  logic                     ready,
    input  logic [DATA_W-1:0]        y,
    input  logic                     O,
    input  logic                     C,
    input  logic                     Z,
    input  logic                     N,
    output logic                     res_valid,
    output logic [DATA_W-1:0]        res_data,
    output logic [3:0]               res_flags,
    output logic                     res_cas_ok,
    output logic                     timeout_err,
    input  logic                     clear_err,
    output logic [15:0]              issued_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [PW:0]   DEPTH_L = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t          state;
    logic [11:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [TW-1:0]   timer;
    logic            push;
    logic            pop;

    // Full is judged on the registered level only, so a same-cycle pop never frees a slot.
    assign host_ready = (fifo_level < DEPTH_L);
    assign push       = host_valid && host_ready;
    assign pop        = (state == S_IDLE) && (fifo_level != '0) && ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (PW + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (PW + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            command      <= '0;
            syscall      <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_flags    <= '0;
            res_cas_ok   <= 1'b0;
            timeout_err  <= 1'b0;
            issued_count <= '0;
            timer        <= '0;
        end else begin
            syscall   <= 1'b0;
            res_valid <= 1'b0;
            if (clear_err) begin
                timeout_err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        command <= mem[rd_ptr];
                        syscall <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    // The controller cannot answer in the first wait cycle; a late ready still beats the timeout.
                    if ((timer != '0) && ready) begin
                        res_data     <= y;
                        res_flags    <= {O, C, Z, N};
                        res_cas_ok   <= (command[11:9] == 3'b111) && (y == DATA_W'(1));
                        res_valid    <= 1'b1;
                        issued_count <= issued_count + 16'd1;
                        state        <= S_CAPTURE;
                    end else if (timer == T_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                S_CAPTURE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_command_issuer.sv
// Directed bench for command_issuer: a queue-based model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_command_issuer;

    localparam int DEPTH   = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [11:0]       host_cmd;
    logic              host_valid;
    logic              host_ready;
    logic [11:0]       command;
    logic              syscall;
    logic              ready;
    logic [DATA_W-1:0] y;
    logic              O, C, Z, N;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [3:0]        res_flags;
    logic              res_cas_ok;
    logic              timeout_err;
    logic              clear_err;
    logic [15:0]       issued_count;
    logic [3:0]        fifo_level;

    int vectors    = 0;
    int miscompares = 0;
    int res_seen   = 0;
    int res_before = 0;

    // Model: queue of pending commands and the age (cycles since syscall) of the one in flight.
    logic [11:0] q[$];
    int          since       = -1;
    logic        e_syscall   = 1'b0;
    logic        e_res_valid = 1'b0;
    logic [11:0] e_command   = '0;
    logic [31:0] e_data      = '0;
    logic [3:0]  e_flags     = '0;
    logic        e_cas       = 1'b0;
    logic        e_terr      = 1'b0;
    logic [15:0] e_count     = '0;

    command_issuer #(
        .DEPTH   (DEPTH),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_cmd     (host_cmd),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .command      (command),
        .syscall      (syscall),
        .ready        (ready),
        .y            (y),
        .O            (O),
        .C            (C),
        .Z            (Z),
        .N            (N),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_flags    (res_flags),
        .res_cas_ok   (res_cas_ok),
        .timeout_err  (timeout_err),
        .clear_err    (clear_err),
        .issued_count (issued_count),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic modelStep();
        bit full;
        bit tset;
        bit cap;
        int nxt;
        if (!rst_n) begin
            q.delete();
            since       = -1;
            e_syscall   = 1'b0;
            e_res_valid = 1'b0;
            e_command   = '0;
            e_data      = '0;
            e_flags     = '0;
            e_cas       = 1'b0;
            e_terr      = 1'b0;
            e_count     = '0;
        end else begin
            full = (q.size() >= DEPTH);
            tset = 1'b0;
            cap  = 1'b0;
            nxt  = -1;
            if (since < 0) begin
                if (!e_res_valid && q.size() > 0 && ready) begin
                    e_command = q.pop_front();
                    nxt = 0;
                end
            end else if (since >= 2 && ready) begin
                cap     = 1'b1;
                e_data  = y;
                e_flags = {O, C, Z, N};
                e_cas   = (e_command[11:9] == 3'b111) && (y == 32'd1);
                e_count = e_count + 16'd1;
            end else if (since == TIMEOUT) begin
                tset = 1'b1;
            end else begin
                nxt = since + 1;
            end
            e_res_valid = cap;
            e_syscall   = (nxt == 0);
            if (tset) begin
                e_terr = 1'b1;
            end else if (clear_err) begin
                e_terr = 1'b0;
            end
            if (host_valid && !full) begin
                q.push_back(host_cmd);
            end
            since = nxt;
        end
    endtask

    task automatic compareAll();
        checkOutput("host_ready", 32'(host_ready), 32'(q.size() < DEPTH));
        checkOutput("fifo_level", 32'(fifo_level), 32'(q.size()));
        checkOutput("syscall", 32'(syscall), 32'(e_syscall));
        checkOutput("command", 32'(command), 32'(e_command));
        checkOutput("res_valid", 32'(res_valid), 32'(e_res_valid));
        checkOutput("res_data", res_data, e_data);
        checkOutput("res_flags", 32'(res_flags), 32'(e_flags));
        checkOutput("res_cas_ok", 32'(res_cas_ok), 32'(e_cas));
        checkOutput("timeout_err", 32'(timeout_err), 32'(e_terr));
        checkOutput("issued_count", 32'(issued_count), 32'(e_count));
        if (res_valid === 1'b1) begin
            res_seen++;
        end
    endtask

    always @(posedge clk or negedge rst_n) modelStep();

    always @(negedge clk) compareAll();

    // Drive one cycle's host/controller inputs, then return just after the next falling edge.
    task automatic applyStimulus(input logic hv, input logic [11:0] hc, input logic rdy);
        host_valid = hv;
        host_cmd   = hc;
        ready      = rdy;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b1;
        host_valid = 1'b0;
        host_cmd   = '0;
        ready      = 1'b0;
        y          = '0;
        {O, C, Z, N} = 4'b0000;
        clear_err  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset host_ready", 32'(host_ready), 32'd1);
        checkOutput("reset fifo_level", 32'(fifo_level), 32'd0);
        checkOutput("reset syscall", 32'(syscall), 32'd0);
        checkOutput("reset issued_count", 32'(issued_count), 32'd0);
        rst_n = 1'b1;

        // Single add: syscall one cycle after the push is visible, result three cycles after syscall.
        y = 32'h5;
        applyStimulus(1'b1, 12'h0C2, 1'b1);
        checkOutput("add level after push", 32'(fifo_level), 32'd1);
        applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("add syscall", 32'(syscall), 32'd1);
        checkOutput("add command", 32'(command), 32'h0C2);
        repeat (2) applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("add no early res_valid", 32'(res_valid), 32'd0);
        applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("add res_valid", 32'(res_valid), 32'd1);
        checkOutput("add res_data", res_data, 32'h5);
        checkOutput("add count", 32'(issued_count), 32'd1);
        checkOutput("add cas_ok", 32'(res_cas_ok), 32'd0);

        // CAS success then failure.
        y = 32'd1;
        {O, C, Z, N} = 4'b1001;
        applyStimulus(1'b1, 12'hE53, 1'b1);
        repeat (4) applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("cas1 res_valid", 32'(res_valid), 32'd1);
        checkOutput("cas1 cas_ok", 32'(res_cas_ok), 32'd1);
        checkOutput("cas1 flags", 32'(res_flags), 32'h9);
        y = 32'd0;
        {O, C, Z, N} = 4'b0010;
        applyStimulus(1'b1, 12'hE53, 1'b1);
        repeat (4) applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("cas2 cas_ok", 32'(res_cas_ok), 32'd0);
        checkOutput("cas2 flags", 32'(res_flags), 32'h2);
        checkOutput("cas2 count", 32'(issued_count), 32'd3);

        // Fill with ready low: the ninth push must be dropped.
        y = 32'd1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, {3'(i), 9'(9'h0A5 + i)}, 1'b0);
        end
        checkOutput("full level", 32'(fifo_level), 32'd8);
        checkOutput("full host_ready", 32'(host_ready), 32'd0);
        res_before = res_seen;
        repeat (42) applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("drain results", 32'(res_seen - res_before), 32'd8);
        checkOutput("drain level", 32'(fifo_level), 32'd0);
        checkOutput("drain count", 32'(issued_count), 32'd11);

        // Timeout: exactly TIMEOUT wait cycles without ready, then abort.
        applyStimulus(1'b1, 12'h123, 1'b1);
        applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("to syscall", 32'(syscall), 32'd1);
        applyStimulus(1'b1, 12'h456, 1'b0);
        repeat (254) applyStimulus(1'b0, 12'h000, 1'b0);
        checkOutput("to not yet", 32'(timeout_err), 32'd0);
        applyStimulus(1'b0, 12'h000, 1'b0);
        checkOutput("to set", 32'(timeout_err), 32'd1);
        checkOutput("to count", 32'(issued_count), 32'd11);
        applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("to next syscall", 32'(syscall), 32'd1);
        checkOutput("to next command", 32'(command), 32'h456);
        repeat (3) applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("to next count", 32'(issued_count), 32'd12);
        clear_err = 1'b1;
        applyStimulus(1'b0, 12'h000, 1'b1);
        clear_err = 1'b0;
        checkOutput("clear_err", 32'(timeout_err), 32'd0);

        // Asynchronous reset while waiting on the controller.
        applyStimulus(1'b1, 12'h0AA, 1'b1);
        applyStimulus(1'b1, 12'h0BB, 1'b1);
        applyStimulus(1'b1, 12'h0CC, 1'b0);
        applyStimulus(1'b0, 12'h000, 1'b0);
        checkOutput("pre-reset command", 32'(command), 32'h0AA);
        checkOutput("pre-reset level", 32'(fifo_level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async command", 32'(command), 32'd0);
        checkOutput("async level", 32'(fifo_level), 32'd0);
        checkOutput("async host_ready", 32'(host_ready), 32'd1);
        checkOutput("async count", 32'(issued_count), 32'd0);
        checkOutput("async res_data", res_data, 32'd0);
        checkOutput("async res_flags", 32'(res_flags), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        res_before = res_seen;
        repeat (6) applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("post-reset no result", 32'(res_seen - res_before), 32'd0);

        // Push and pop in the same cycle at level 3.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 12'(12'h301 + i), 1'b0);
        end
        checkOutput("pp level before", 32'(fifo_level), 32'd3);
        applyStimulus(1'b1, 12'h304, 1'b1);
        checkOutput("pp level after", 32'(fifo_level), 32'd3);
        checkOutput("pp head command", 32'(command), 32'h301);
        repeat (22) applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("pp count", 32'(issued_count), 32'd4);
        checkOutput("pp level empty", 32'(fifo_level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
